// File: rtl/ysyx_040066_wb_pkg.sv
// Shared encodings and the writeback stage-register entry for ysyx_040066_wb_arb.
// Datapath fields are sized for the widest build (XLEN=64); narrower builds use the low bits.
package ysyx_040066_wb_pkg;

   localparam logic [1:0] MOP_B = 2'd0;
   localparam logic [1:0] MOP_H = 2'd1;
   localparam logic [1:0] MOP_W = 2'd2;
   localparam logic [1:0] MOP_D = 2'd3;
   localparam int         MOP_U = 2;

   localparam int CH_PIPE = 0;
   localparam int CHW     = 8;

   typedef struct packed {
      logic           valid;
      logic [CHW-1:0] ch;
      logic           wen;
      logic [4:0]     rd;
      logic [63:0]    data;
      logic           memrd;
      logic           memwr;
      logic [2:0]     memop;
      logic [2:0]     addr_low;
      logic [63:0]    pc;
   } wb_entry_t;

endpackage

// File: rtl/ysyx_040066_load_align.sv
// Load data lane select and sign/zero extension with misalignment flag.
// Purely combinational; addr_low picks the byte offset inside the memory word.
module ysyx_040066_load_align
   import ysyx_040066_wb_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int AL   = $clog2(XLEN/8)
) (
   input  logic [XLEN-1:0] rdata_i,
   input  logic [2:0]      memop_i,
   input  logic [AL-1:0]   addr_low_i,
   output logic [XLEN-1:0] data_o,
   output logic            misalign_o
);

   logic [XLEN-1:0] shifted;

   assign shifted = rdata_i >> {addr_low_i, 3'b000};

   always_comb begin
      data_o     = rdata_i;
      misalign_o = 1'b0;
      case (memop_i[1:0])
         MOP_B: begin
            data_o = memop_i[MOP_U] ? XLEN'(shifted[7:0]) : XLEN'($signed(shifted[7:0]));
         end
         MOP_H: begin
            data_o     = memop_i[MOP_U] ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
            misalign_o = addr_low_i[0];
         end
         MOP_W: begin
            // a word is the full datapath on 32-bit builds: pass through
            if (XLEN > 32)
               data_o = memop_i[MOP_U] ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
            misalign_o = (addr_low_i[1:0] != 2'b00);
         end
         MOP_D: begin
            misalign_o = (addr_low_i != '0);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ysyx_040066_wb_arb.sv
// Writeback stage: arbitrates the pipeline and long-latency units onto the single RF write port.
// Starvation guard for long-latency channels is built when YSYX_040066_WB_STARVE_EN is defined.
module ysyx_040066_wb_arb
   import ysyx_040066_wb_pkg::*;
#(
   parameter int XLEN       = 64,
   parameter int NCH        = 3,
   parameter int STARVE_LIM = 4,
   parameter int AL         = $clog2(XLEN/8)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NCH-1:0]      in_valid,
   output logic [NCH-1:0]      in_ready,
   input  logic [NCH-1:0]      in_wen,
   input  logic [5*NCH-1:0]    in_rd,
   input  logic [XLEN*NCH-1:0] in_data,
   input  logic                p_memrd,
   input  logic                p_memwr,
   input  logic [2:0]          p_memop,
   input  logic [AL-1:0]       p_addr_low,
   input  logic [63:0]         p_pc,
   input  logic [XLEN-1:0]     mem_rdata,
   input  logic                mem_err,
   output logic                rf_wen,
   output logic [4:0]          rf_rd,
   output logic [XLEN-1:0]     rf_data,
   output logic                commit_valid,
   output logic [63:0]         commit_pc,
   output logic                wb_err
);

   localparam int CW = $clog2(NCH);

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("ysyx_040066_wb_arb: XLEN must be 32 or 64");
   end
   if (NCH < 2 || STARVE_LIM < 1) begin : g_bad_cfg
      $error("ysyx_040066_wb_arb: need NCH >= 2 and STARVE_LIM >= 1");
   end

   wb_entry_t       s_q, s_d;
   logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]   rr_win;
   logic            rr_found;
   logic            preempt;
   logic [NCH-1:0]  grant;
   logic [XLEN-1:0] ld_data;
   logic            ld_mis;
   logic            err;
   logic            live;

   // channel index 'off' steps after base, wrapping within 1..NCH-1
   function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] base, input int off);
      int idx;
      idx = int'(base) + off;
      if (idx > NCH-1) idx = idx - (NCH-1);
      return CW'(idx);
   endfunction

   always_comb begin
      rr_found = 1'b0;
      rr_win   = '0;
      for (int off = 0; off < NCH-1; off++) begin
         if (!rr_found && in_valid[rr_idx(rr_ptr_q, off)]) begin
            rr_found = 1'b1;
            rr_win   = rr_idx(rr_ptr_q, off);
         end
      end
   end

`ifdef YSYX_040066_WB_STARVE_EN
   localparam int SCW = $clog2(STARVE_LIM+1);
   logic [SCW-1:0] starve_q, starve_d;

   assign preempt = (starve_q == SCW'(STARVE_LIM));

   always_comb begin
      starve_d = starve_q;
      if (|grant[NCH-1:1])
         starve_d = '0;
      else if (|in_valid[NCH-1:1] && !preempt)
         starve_d = starve_q + SCW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) starve_q <= '0;
      else      starve_q <= starve_d;
   end
`else
   assign preempt = 1'b0;
`endif

   always_comb begin
      grant = '0;
      if (rst) begin
         if (in_valid[CH_PIPE] && !preempt) grant[CH_PIPE] = 1'b1;
         else if (rr_found)                 grant[rr_win]  = 1'b1;
      end
   end

   assign in_ready = grant;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (|grant[NCH-1:1])
         rr_ptr_d = (rr_win == CW'(NCH-1)) ? CW'(1) : rr_win + CW'(1);
   end

   always_comb begin
      s_d       = '0;
      s_d.valid = |grant;
      if (grant[CH_PIPE]) begin
         s_d.ch       = CHW'(CH_PIPE);
         s_d.wen      = in_wen[CH_PIPE];
         s_d.rd       = in_rd[5*CH_PIPE +: 5];
         s_d.data     = 64'(in_data[XLEN*CH_PIPE +: XLEN]);
         s_d.memrd    = p_memrd;
         s_d.memwr    = p_memwr;
         s_d.memop    = p_memop;
         s_d.addr_low = 3'(p_addr_low);
         s_d.pc       = p_pc;
      end
      for (int i = 1; i < NCH; i++) begin
         if (grant[i]) begin
            s_d.ch   = CHW'(i);
            s_d.wen  = in_wen[i];
            s_d.rd   = in_rd[5*i +: 5];
            s_d.data = 64'(in_data[XLEN*i +: XLEN]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s_q      <= '0;
         rr_ptr_q <= CW'(1);
      end else begin
         s_q      <= s_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   ysyx_040066_load_align #(.XLEN(XLEN), .AL(AL)) u_load_align (
      .rdata_i    (mem_rdata),
      .memop_i    (s_q.memop),
      .addr_low_i (s_q.addr_low[AL-1:0]),
      .data_o     (ld_data),
      .misalign_o (ld_mis)
   );

   // retire is gated by rst so an entry caught by reset never writes
   always_comb begin
      live = s_q.valid && rst;
      err  = ((s_q.memrd || s_q.memwr) && mem_err)
          || (s_q.memrd && (ld_mis || (XLEN == 32 && s_q.memop[1:0] == MOP_D)));
      rf_wen       = live && s_q.wen && !err && (s_q.rd != 5'd0);
      rf_rd        = live ? s_q.rd : 5'd0;
      rf_data      = '0;
      if (live) rf_data = s_q.memrd ? ld_data : s_q.data[XLEN-1:0];
      commit_valid = live;
      commit_pc    = (live && s_q.ch == CHW'(CH_PIPE)) ? s_q.pc : 64'd0;
      wb_err       = live && err;
   end

endmodule

// File: tb/tb_ysyx_040066_wb_arb.sv
// Randomized scoreboard bench for ysyx_040066_wb_arb with a behavioural arbitration/retire model.
module tb_ysyx_040066_wb_arb;

   localparam int XLEN       = 64;
   localparam int NCH        = 3;
   localparam int STARVE_LIM = 4;
   localparam int AL         = 3;
   localparam int NCYC       = 430;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic [NCH-1:0]      in_valid = '0;
   logic [NCH-1:0]      in_ready;
   logic [NCH-1:0]      in_wen = '0;
   logic [5*NCH-1:0]    in_rd = '0;
   logic [XLEN*NCH-1:0] in_data = '0;
   logic                p_memrd = 1'b0;
   logic                p_memwr = 1'b0;
   logic [2:0]          p_memop = '0;
   logic [AL-1:0]       p_addr_low = '0;
   logic [63:0]         p_pc = '0;
   logic [XLEN-1:0]     mem_rdata = '0;
   logic                mem_err = 1'b0;
   logic                rf_wen;
   logic [4:0]          rf_rd;
   logic [XLEN-1:0]     rf_data;
   logic                commit_valid;
   logic [63:0]         commit_pc;
   logic                wb_err;

   ysyx_040066_wb_arb #(.XLEN(XLEN), .NCH(NCH), .STARVE_LIM(STARVE_LIM), .AL(AL)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
      .in_rd(in_rd), .in_data(in_data), .p_memrd(p_memrd), .p_memwr(p_memwr),
      .p_memop(p_memop), .p_addr_low(p_addr_low), .p_pc(p_pc), .mem_rdata(mem_rdata),
      .mem_err(mem_err), .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_data(rf_data),
      .commit_valid(commit_valid), .commit_pc(commit_pc), .wb_err(wb_err)
   );

   always #5 clk = ~clk;

   // kind: 0 = plain result, 1 = load, 2 = store
   typedef struct {
      bit        v;
      int        kind;
      bit        wen;
      bit [4:0]  rd;
      bit [63:0] data;
      bit [2:0]  op;
      bit [2:0]  al;
      bit [63:0] pc;
      bit [63:0] rdat;
      bit        merr;
   } req_t;

   typedef struct {
      bit        wen;
      bit [4:0]  rd;
      bit [63:0] data;
      bit [63:0] pc;
      bit        err;
      int        due;
   } exp_t;

   req_t pend [NCH];
   exp_t sb [$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   m_ptr = 1;
   int   m_starve = 0;
   int   dir_idx = 0;
   bit        mem_pend = 1'b0;
   bit [63:0] mem_nd = '0;
   bit        mem_ne = 1'b0;

   // directed channel-0 opening: signed byte, unsigned byte, misaligned half, write to x0
   int       d_kind [4] = '{1, 1, 1, 0};
   bit [2:0] d_op   [4] = '{3'b000, 3'b100, 3'b001, 3'b000};
   bit [2:0] d_al   [4] = '{3'd3, 3'd3, 3'd1, 3'd0};
   bit [4:0] d_rd   [4] = '{5'd5, 5'd6, 5'd7, 5'd0};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
   endtask

   function automatic req_t new_req(input int ch, input int d);
      req_t r;
      int   sz;
      r.v    = 1'b1;
      r.kind = 0;
      r.wen  = ($urandom_range(0, 3) != 0);
      r.rd   = 5'($urandom);
      r.data = {$urandom, $urandom};
      r.op   = 3'($urandom);
      r.al   = 3'($urandom);
      r.pc   = {$urandom, $urandom};
      r.rdat = {$urandom, $urandom};
      r.merr = ($urandom_range(0, 7) == 0);
      if (ch == 0) begin
         r.kind = $urandom_range(0, 2);
         sz = 1 << r.op[1:0];
         if ($urandom_range(0, 1) == 1) r.al = r.al & 3'(~(sz - 1));
         if (d >= 0) begin
            r.kind = d_kind[d];
            r.op   = d_op[d];
            r.al   = d_al[d];
            r.rd   = d_rd[d];
            r.wen  = 1'b1;
            r.rdat = 64'h0000_0000_8000_0000;
            r.merr = 1'b0;
         end
      end
      return r;
   endfunction

   // expected retirement from the architectural rules, byte arithmetic only
   function automatic exp_t expect_of(input req_t r, input int ch);
      exp_t      e;
      int        sz;
      bit [63:0] v;
      bit [63:0] m;
      e.wen = r.wen;
      e.rd  = r.rd;
      e.pc  = (ch == 0) ? r.pc : 64'd0;
      e.err = 1'b0;
      e.due = 0;
      v     = r.data;
      if (ch == 0 && r.kind == 1) begin
         sz    = 1 << r.op[1:0];
         e.err = r.merr || ((int'(r.al) % sz) != 0);
         v     = r.rdat >> (8 * int'(r.al));
         if (sz < 8) begin
            m = (64'd1 << (8 * sz)) - 64'd1;
            v = v & m;
            if (!r.op[2] && v[8*sz-1]) v = v | ~m;
         end
      end else if (ch == 0 && r.kind == 2) begin
         e.err = r.merr;
      end
      e.data = v;
      return e;
   endfunction

   initial begin : driver
      int   p [NCH];
      int   g;
      int   cand;
      bit   pre;
      bit   any_long;
      exp_t e;
      for (int i = 0; i < NCH; i++) pend[i].v = 1'b0;
      for (int c = 1; c <= NCYC; c++) begin
         @(negedge clk);
         cyc = c;
         rst = !((c <= 3) || (c == 200) || (c == 201));

         if (c <= 3)        begin p[0] = 0;   p[1] = 0;   p[2] = 0;   end
         else if (c <= 12)  begin p[0] = (dir_idx < 4) ? 100 : 0; p[1] = 0; p[2] = 0; end
         else if (c <= 40)  begin p[0] = 100; p[1] = 100; p[2] = 0;   end
         else if (c <= 60)  begin p[0] = 0;   p[1] = 100; p[2] = 100; end
         else if (c <= 400) begin p[0] = 60;  p[1] = 30;  p[2] = 30;  end
         else               begin p[0] = 0;   p[1] = 0;   p[2] = 0;   end

         for (int i = 0; i < NCH; i++) begin
            if (!pend[i].v && $urandom_range(0, 99) < p[i]) begin
               if (i == 0 && c <= 12 && dir_idx < 4) begin
                  pend[i] = new_req(i, dir_idx);
                  dir_idx++;
               end else begin
                  pend[i] = new_req(i, -1);
               end
            end
         end

         for (int i = 0; i < NCH; i++) begin
            in_valid[i]           = pend[i].v;
            in_wen[i]             = pend[i].wen;
            in_rd[5*i +: 5]       = pend[i].rd;
            in_data[XLEN*i +: XLEN] = pend[i].data;
         end
         p_memrd    = (pend[0].kind == 1);
         p_memwr    = (pend[0].kind == 2);
         p_memop    = pend[0].op;
         p_addr_low = pend[0].al;
         p_pc       = pend[0].pc;
         if (mem_pend) begin
            mem_rdata = mem_nd;
            mem_err   = mem_ne;
            mem_pend  = 1'b0;
         end else begin
            mem_rdata = {$urandom, $urandom};
            mem_err   = $urandom_range(0, 1) == 1;
         end

         #1;
         g        = -1;
         pre      = 1'b0;
         any_long = 1'b0;
`ifdef YSYX_040066_WB_STARVE_EN
         pre = (m_starve == STARVE_LIM);
`endif
         for (int k = 1; k < NCH; k++) any_long = any_long | pend[k].v;
         if (rst) begin
            if (pend[0].v && !pre) g = 0;
            else begin
               for (int k = 0; k < NCH-1; k++) begin
                  cand = 1 + ((m_ptr - 1 + k) % (NCH - 1));
                  if (g < 0 && pend[cand].v) g = cand;
               end
            end
         end
         check("in_ready", 64'(in_ready), (g >= 0) ? (64'd1 << g) : 64'd0);

         if (g >= 0) begin
            e     = expect_of(pend[g], g);
            e.due = c + 1;
            sb.push_back(e);
            if (g == 0) begin
               mem_pend = 1'b1;
               mem_nd   = pend[0].rdat;
               mem_ne   = pend[0].merr;
            end
            pend[g].v = 1'b0;
         end

         if (!rst) begin
            m_ptr    = 1;
            m_starve = 0;
         end else if (g >= 1) begin
            m_ptr    = (g % (NCH - 1)) + 1;
            m_starve = 0;
         end else if (any_long) begin
            m_starve++;
         end
      end
      #3;
      check("drain_queue_empty", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin : monitor
      exp_t e;
      bit   w;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (!rst) begin
               check("reset_commit_valid", 64'(commit_valid), 64'd0);
               check("reset_rf_wen", 64'(rf_wen), 64'd0);
            end else begin
               w = e.wen && !e.err && (e.rd != 5'd0);
               check("commit_valid", 64'(commit_valid), 64'd1);
               check("rf_wen", 64'(rf_wen), 64'(w));
               check("wb_err", 64'(wb_err), 64'(e.err));
               check("commit_pc", commit_pc, e.pc);
               if (w) begin
                  check("rf_rd", 64'(rf_rd), 64'(e.rd));
                  check("rf_data", 64'(rf_data), e.data);
               end
            end
         end else begin
            check("idle_commit_valid", 64'(commit_valid), 64'd0);
            check("idle_rf_wen", 64'(rf_wen), 64'd0);
         end
      end
   end

endmodule
